// File: rtl/rc_pwm_rx.sv
// rc_pwm_rx: multi-channel RC servo PWM receiver.
// Each channel measures the high time of its radio_in bit in microseconds
// (one clk_1M cycle per us), validates it and maps it onto an unsigned command.
// A per-channel watchdog forces the failsafe command when pulses stop arriving.
module rc_pwm_rx #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CMD_W      = 10,
    parameter int unsigned CTR_W      = 16,
    parameter int unsigned MIN_US     = 987,
    parameter int unsigned PMIN_US    = 500,
    parameter int unsigned PMAX_US    = 2500,
    parameter int unsigned TIMEOUT_US = 25000,
    parameter int unsigned FS_CMD     = 0
) (
    input  logic                 clk_1M,
    input  logic                 rst,
    input  logic [NCH-1:0]       radio_in,
    output logic [NCH*CMD_W-1:0] cmd_out,
    output logic [NCH-1:0]       valid,
    output logic [NCH-1:0]       update,
    output logic                 failsafe
);

    localparam logic [CTR_W-1:0] MIN_C     = CTR_W'(MIN_US);
    localparam logic [CTR_W-1:0] PMIN_C    = CTR_W'(PMIN_US);
    localparam logic [CTR_W-1:0] PMAX_C    = CTR_W'(PMAX_US);
    localparam logic [CTR_W-1:0] TMO_C     = CTR_W'(TIMEOUT_US);
    localparam logic [CTR_W-1:0] TMO_LAST  = CTR_W'(TIMEOUT_US - 1);
    localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CMD_MAX_C = CTR_W'((2 ** CMD_W) - 1);
    localparam logic [CMD_W-1:0] FS_C      = CMD_W'(FS_CMD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } state_t;

    // Synchronizer contents are not meaningful until two edges after reset;
    // IDLE must not treat the cleared (low) flops as a real low level.
    logic [1:0]     warm;
    logic           warm_done;
    logic [NCH-1:0] valid_nxt;

    assign warm_done = (warm == 2'd2);

    // Post-reset warm-up counter for the input synchronizers
    always_ff @(posedge clk_1M) begin
        if (rst) begin
            warm <= 2'd0;
        end else if (!warm_done) begin
            warm <= warm + 2'd1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state;
        logic [2:0]       sync;
        logic             lvl;
        logic             rise;
        logic [CTR_W-1:0] width;
        logic [CTR_W-1:0] diff;
        logic [CTR_W-1:0] tmo;
        logic [CTR_W-1:0] tmo_d;
        logic             acc_pend;
        logic [CMD_W-1:0] cmd_map;
        logic [CMD_W-1:0] cmd_q;
        logic [CMD_W-1:0] cmd_d;
        logic             valid_q;
        logic             valid_d;
        logic             upd_q;

        // Two synchronizer stages followed by a delay stage for edge detection
        always_ff @(posedge clk_1M) begin
            if (rst) begin
                sync <= 3'b000;
            end else begin
                sync <= {sync[1:0], radio_in[g]};
            end
        end

        assign lvl  = sync[1];
        assign rise = sync[1] & ~sync[2];

        // Pulse measurement FSM; acc_pend flags a pulse accepted on the fall
        always_ff @(posedge clk_1M) begin
            if (rst) begin
                state    <= IDLE;
                width    <= '0;
                acc_pend <= 1'b0;
            end else begin
                acc_pend <= 1'b0;
                case (state)
                    IDLE: begin
                        if (warm_done && !lvl) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (rise) begin
                            state <= HIGH;
                            width <= CTR_ONE;
                        end
                    end
                    HIGH: begin
                        if (lvl) begin
                            if (width > PMAX_C) begin
                                state <= IDLE;
                            end else if (width != CTR_MAX) begin
                                width <= width + CTR_ONE;
                            end
                        end else begin
                            // Low while HIGH is always a falling edge
                            state    <= ARMED;
                            acc_pend <= (width >= PMIN_C) && (width <= PMAX_C);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        // Width to command mapping with clamping at both ends
        always_comb begin
            diff    = width - MIN_C;
            cmd_map = '0;
            if (width < MIN_C) begin
                cmd_map = '0;
            end else if (diff > CMD_MAX_C) begin
                cmd_map = {CMD_W{1'b1}};
            end else begin
                cmd_map = CMD_W'(diff);
            end
        end

        // Next output state: acceptance wins over watchdog expiry
        always_comb begin
            tmo_d   = tmo;
            cmd_d   = cmd_q;
            valid_d = valid_q;
            if (acc_pend) begin
                tmo_d   = '0;
                cmd_d   = cmd_map;
                valid_d = 1'b1;
            end else begin
                if (tmo != TMO_C) begin
                    tmo_d = tmo + CTR_ONE;
                end
                if (tmo == TMO_LAST) begin
                    cmd_d   = FS_C;
                    valid_d = 1'b0;
                end
            end
        end

        // Output and watchdog registers
        always_ff @(posedge clk_1M) begin
            if (rst) begin
                tmo     <= '0;
                cmd_q   <= FS_C;
                valid_q <= 1'b0;
                upd_q   <= 1'b0;
            end else begin
                tmo     <= tmo_d;
                cmd_q   <= cmd_d;
                valid_q <= valid_d;
                upd_q   <= acc_pend;
            end
        end

        assign valid_nxt[g]                = valid_d;
        assign cmd_out[g*CMD_W +: CMD_W]   = cmd_q;
        assign valid[g]                    = valid_q;
        assign update[g]                   = upd_q;
    end

    // Failsafe flag tracks the registered valid vector on the same edge
    always_ff @(posedge clk_1M) begin
        if (rst) begin
            failsafe <= 1'b1;
        end else begin
            failsafe <= ~&valid_nxt;
        end
    end

endmodule
